// File: rtl/pwm_fade_sequencer.sv
// pwm_fade_sequencer: Avalon-MM programmable fade engine.
// It drives a PWM stage with a triangular duty ramp (UP to MAX, then DOWN to 0).
// Ports:
//   clk, reset (async, active-high)
//   address/write/read/writedata/readdata: Avalon-MM slave
//   duty_out/period_out/duty_be: PWM stage
//   irq: fade-complete interrupt, present only with PWM_FADE_IRQ_EN defined
// Optional macro: PWM_FADE_IRQ_EN.
module pwm_fade_sequencer #(
  parameter int N = 32,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [2:0]   address,
  input  logic         write,
  input  logic         read,
  input  logic [N-1:0] writedata,
  output logic [N-1:0] readdata,
  output logic [N-1:0] duty_out,
  output logic [N:0]   period_out,
  output logic [M-1:0] duty_be
`ifdef PWM_FADE_IRQ_EN
  ,
  output logic         irq
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_t       state, state_nx;
  logic         en, loop_en, done;
  logic [N-1:0] period, step, max_v, cnt;
  logic [N-1:0] duty_nx, up_val, dn_val;
  logic [N-1:0] period_eff, rd_mux;
  logic [N:0]   up_sum;
  logic         tick, strobe, set_done, clr_en;
  logic         ctrl_wr, per_wr, stat_wr;

  assign ctrl_wr = write && (address == 3'd0);
  assign per_wr  = write && (address == 3'd1);
  assign stat_wr = write && (address == 3'd5);

  assign period_out = {1'b0, period};

  // PERIOD of 0 behaves as 1 so a tick fires every cycle.
  assign period_eff = (period == '0) ? ONE : period;
  assign tick       = (cnt == period_eff);

  // Extra carry bit keeps the saturation compare free of wrap-around.
  assign up_sum = {1'b0, duty_out} + {1'b0, step};
  assign up_val = (up_sum >= {1'b0, max_v}) ? max_v : up_sum[N-1:0];
  assign dn_val = (duty_out > step) ? (duty_out - step) : '0;

  always_comb begin
    state_nx = state;
    duty_nx  = duty_out;
    strobe   = 1'b0;
    set_done = 1'b0;
    clr_en   = 1'b0;
    // A CTRL write owns the cycle; any coincident tick is dropped.
    if (ctrl_wr) begin
      if (!writedata[0]) begin
        state_nx = ST_IDLE;
      end else if (state == ST_IDLE) begin
        state_nx = ST_UP;
        duty_nx  = '0;
        strobe   = 1'b1;
      end
    end else begin
      unique case (state)
        ST_IDLE: ;
        ST_UP: begin
          if (tick) begin
            duty_nx = up_val;
            strobe  = 1'b1;
            if (up_val == max_v) state_nx = ST_DOWN;
          end
        end
        ST_DOWN: begin
          if (tick) begin
            duty_nx = dn_val;
            strobe  = 1'b1;
            if (dn_val == '0) state_nx = loop_en ? ST_UP : ST_DONE;
          end
        end
        ST_DONE: begin
          set_done = 1'b1;
          clr_en   = 1'b1;
          state_nx = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      3'd0:    rd_mux[1:0] = {loop_en, en};
      3'd1:    rd_mux = period;
      3'd2:    rd_mux = step;
      3'd3:    rd_mux = max_v;
      3'd4:    rd_mux = duty_out;
      3'd5:    rd_mux[2:0] = {done, state};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en       <= 1'b0;
      loop_en  <= 1'b0;
      period   <= '0;
      step     <= '0;
      max_v    <= '0;
      done     <= 1'b0;
      cnt      <= ONE;
      duty_out <= '0;
      duty_be  <= '0;
      readdata <= '0;
    end else begin
      if (ctrl_wr) begin
        en      <= writedata[0];
        loop_en <= writedata[1];
      end else if (clr_en) begin
        en <= 1'b0;
      end
      if (per_wr) period <= writedata;
      if (write && address == 3'd2) step <= writedata;
      if (write && address == 3'd3) max_v <= writedata;
      // Completion wins over a same-cycle clear so it is never lost.
      if (set_done)     done <= 1'b1;
      else if (stat_wr) done <= 1'b0;
      cnt      <= (per_wr || tick) ? ONE : cnt + ONE;
      duty_out <= duty_nx;
      duty_be  <= strobe ? {M{1'b1}} : {M{1'b0}};
      if (read) readdata <= rd_mux;
    end
  end

`ifdef PWM_FADE_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else       irq <= done && !stat_wr;
  end
`endif

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// tb_pwm_fade_sequencer: directed self-checking bench for pwm_fade_sequencer.
// Exercises register access, fades, looping, boundaries, reset and irq.
module tb_pwm_fade_sequencer;
  localparam int N = 32;
  localparam int M = 4;
  localparam logic [M-1:0] BE1 = '1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [2:0]   address = '0;
  logic         write = 1'b0;
  logic         read = 1'b0;
  logic [N-1:0] writedata = '0;
  logic [N-1:0] readdata;
  logic [N-1:0] duty_out;
  logic [N:0]   period_out;
  logic [M-1:0] duty_be;
`ifdef PWM_FADE_IRQ_EN
  logic         irq;
`endif

  int checks = 0;
  int errors = 0;

  logic [N-1:0] sv [0:15];
  logic [M-1:0] sb [0:15];
  int           sc [0:15];
  int           got;

  pwm_fade_sequencer #(.N(N), .M(M)) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .write(write),
    .read(read),
    .writedata(writedata),
    .readdata(readdata),
    .duty_out(duty_out),
    .period_out(period_out),
    .duty_be(duty_be)
`ifdef PWM_FADE_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic step1();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [N-1:0] d);
    step1();
    write = 1'b1;
    address = a;
    writedata = d;
    step1();
    write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [N-1:0] d);
    step1();
    read = 1'b1;
    address = a;
    step1();
    read = 1'b0;
    d = readdata;
  endtask

  // Records every strobe (value, enable, cycle) until n seen or budget ends.
  task automatic collect(input int n, input int budget);
    int cyc;
    cyc = 0;
    got = 0;
    while (got < n && cyc < budget) begin
      if (duty_be !== '0) begin
        sv[got] = duty_out;
        sb[got] = duty_be;
        sc[got] = cyc;
        got++;
      end
      if (got < n) begin
        step1();
        cyc++;
      end
    end
  endtask

  task automatic test_reset();
    logic [N-1:0] r;
    step1();
    step1();
    checks++;
    if (duty_out !== '0 || duty_be !== '0 || readdata !== '0 ||
        period_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs duty=%h be=%h rd=%h per=%h want 0",
               duty_out, duty_be, readdata, period_out);
    end
`ifdef PWM_FADE_IRQ_EN
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq got %b want 0", irq);
    end
`endif
    @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 6; a++) begin
      bus_read(3'(a), r);
      checks++;
      if (r !== '0) begin
        errors++;
        $display("FAIL reset_reg%0d got %h want 0", a, r);
      end
    end
  endtask

  task automatic test_regs();
    logic [N-1:0] r;
    bus_write(3'd1, 32'h1234_5678);
    bus_write(3'd2, 32'h0000_00A5);
    bus_write(3'd3, 32'hCAFE_F00D);
    bus_write(3'd0, 32'h0000_0002);
    bus_write(3'd4, 32'hFFFF_FFFF);
    bus_write(3'd6, 32'hFFFF_FFFF);
    bus_read(3'd1, r);
    checks++;
    if (r !== 32'h1234_5678) begin
      errors++;
      $display("FAIL rd_period got %h want 12345678", r);
    end
    checks++;
    if (period_out !== 33'h0_1234_5678) begin
      errors++;
      $display("FAIL period_out got %h want 012345678", period_out);
    end
    bus_read(3'd2, r);
    checks++;
    if (r !== 32'h0000_00A5) begin
      errors++;
      $display("FAIL rd_step got %h want a5", r);
    end
    bus_read(3'd3, r);
    checks++;
    if (r !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL rd_max got %h want cafef00d", r);
    end
    bus_read(3'd0, r);
    checks++;
    if (r !== 32'h2) begin
      errors++;
      $display("FAIL rd_ctrl got %h want 2", r);
    end
    bus_read(3'd4, r);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("FAIL rd_duty_ro got %h want 0", r);
    end
    bus_read(3'd6, r);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("FAIL rd_unmapped6 got %h want 0", r);
    end
    bus_read(3'd7, r);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("FAIL rd_unmapped7 got %h want 0", r);
    end
    bus_write(3'd0, 32'h0);
  endtask

  task automatic test_fade();
    logic [N-1:0] r;
    logic [N-1:0] ev [9] = '{0, 64, 128, 192, 255, 191, 127, 63, 0};
    bus_write(3'd5, 32'h0);
    bus_write(3'd1, 32'd4);
    bus_write(3'd2, 32'd64);
    bus_write(3'd3, 32'd255);
    bus_write(3'd0, 32'h1);
    collect(9, 100);
    checks++;
    if (got != 9) begin
      errors++;
      $display("FAIL fade_count got %0d want 9", got);
    end
    for (int i = 0; i < got; i++) begin
      checks++;
      if (sv[i] !== ev[i] || sb[i] !== BE1) begin
        errors++;
        $display("FAIL fade_step%0d got %0d/%h want %0d/%h",
                 i, sv[i], sb[i], ev[i], BE1);
      end
      if (i >= 2) begin
        checks++;
        if (sc[i] - sc[i-1] != 4) begin
          errors++;
          $display("FAIL fade_gap%0d got %0d want 4", i, sc[i] - sc[i-1]);
        end
      end else if (i == 1) begin
        checks++;
        if (sc[1] < 1 || sc[1] > 4) begin
          errors++;
          $display("FAIL fade_gap1 got %0d want 1..4", sc[1]);
        end
      end
    end
    step1();
    step1();
    checks++;
    if (duty_be !== '0 || duty_out !== '0) begin
      errors++;
      $display("FAIL fade_hold got %0d/%h want 0/0", duty_out, duty_be);
    end
    bus_read(3'd5, r);
    checks++;
    if (r !== 32'h4) begin
      errors++;
      $display("FAIL fade_status got %h want 4", r);
    end
    bus_read(3'd0, r);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("FAIL fade_ctrl got %h want 0", r);
    end
  endtask

  task automatic test_loop();
    logic [N-1:0] r;
    logic [N-1:0] f;
    bit bad;
    logic [N-1:0] ev [10] = '{0, 64, 128, 192, 255, 191, 127, 63, 0, 64};
    bus_write(3'd5, 32'h0);
    bus_write(3'd0, 32'h3);
    collect(10, 100);
    checks++;
    if (got != 10) begin
      errors++;
      $display("FAIL loop_count got %0d want 10", got);
    end
    for (int i = 0; i < got; i++) begin
      checks++;
      if (sv[i] !== ev[i]) begin
        errors++;
        $display("FAIL loop_step%0d got %0d want %0d", i, sv[i], ev[i]);
      end
    end
    bus_read(3'd5, r);
    checks++;
    if (r !== 32'h1) begin
      errors++;
      $display("FAIL loop_status got %h want 1", r);
    end
    bus_write(3'd0, 32'h2);
    f = duty_out;
    checks++;
    if (duty_be !== '0 || (f !== 32'd64 && f !== 32'd128)) begin
      errors++;
      $display("FAIL loop_stop got %0d/%h want 64|128/0", f, duty_be);
    end
    bad = 1'b0;
    repeat (12) begin
      step1();
      if (duty_be !== '0 || duty_out !== f) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL loop_freeze got duty=%0d be=%h want %0d/0",
               duty_out, duty_be, f);
    end
    bus_read(3'd5, r);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("FAIL loop_idle got %h want 0", r);
    end
    bus_write(3'd0, 32'h0);
  endtask

  task automatic test_fast();
    logic [N-1:0] r;
    logic [N-1:0] ev [7] = '{0, 1, 2, 3, 2, 1, 0};
    bus_write(3'd5, 32'h0);
    bus_write(3'd1, 32'd0);
    bus_write(3'd2, 32'd1);
    bus_write(3'd3, 32'd3);
    bus_write(3'd0, 32'h1);
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (duty_out !== ev[i] || duty_be !== BE1) begin
        errors++;
        $display("FAIL fast_cyc%0d got %0d/%h want %0d/%h",
                 i, duty_out, duty_be, ev[i], BE1);
      end
      step1();
    end
    checks++;
    if (duty_be !== '0 || duty_out !== '0) begin
      errors++;
      $display("FAIL fast_end got %0d/%h want 0/0", duty_out, duty_be);
    end
    bus_read(3'd5, r);
    checks++;
    if (r !== 32'h4) begin
      errors++;
      $display("FAIL fast_status got %h want 4", r);
    end
  endtask

  task automatic test_step_zero();
    logic [N-1:0] r;
    bus_write(3'd5, 32'h0);
    bus_write(3'd2, 32'd0);
    bus_write(3'd3, 32'd5);
    bus_write(3'd0, 32'h1);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (duty_out !== '0 || duty_be !== BE1) begin
        errors++;
        $display("FAIL step0_cyc%0d got %0d/%h want 0/%h",
                 i, duty_out, duty_be, BE1);
      end
      step1();
    end
    bus_write(3'd0, 32'h0);
    checks++;
    if (duty_be !== '0) begin
      errors++;
      $display("FAIL step0_stop got %h want 0", duty_be);
    end
    bus_read(3'd5, r);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("FAIL step0_status got %h want 0", r);
    end
  endtask

  task automatic test_max_zero();
    logic [N-1:0] r;
    bus_write(3'd2, 32'd5);
    bus_write(3'd3, 32'd0);
    bus_write(3'd0, 32'h1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (duty_out !== '0 || duty_be !== BE1) begin
        errors++;
        $display("FAIL max0_cyc%0d got %0d/%h want 0/%h",
                 i, duty_out, duty_be, BE1);
      end
      step1();
    end
    checks++;
    if (duty_be !== '0) begin
      errors++;
      $display("FAIL max0_end got %h want 0", duty_be);
    end
    bus_read(3'd5, r);
    checks++;
    if (r !== 32'h4) begin
      errors++;
      $display("FAIL max0_status got %h want 4", r);
    end
  endtask

  task automatic test_period_restart();
    logic [M-1:0] seen [3];
    bus_write(3'd5, 32'h0);
    bus_write(3'd1, 32'd3);
    bus_write(3'd2, 32'd1);
    bus_write(3'd3, 32'd100);
    bus_write(3'd0, 32'h1);
    step1();
    bus_write(3'd1, 32'd3);
    for (int i = 0; i < 3; i++) begin
      step1();
      seen[i] = duty_be;
    end
    checks++;
    if (seen[0] !== '0 || seen[1] !== '0 || seen[2] !== BE1) begin
      errors++;
      $display("FAIL per_restart got %h,%h,%h want 0,0,%h",
               seen[0], seen[1], seen[2], BE1);
    end
    bus_write(3'd0, 32'h0);
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] r;
    bit bad;
    bus_write(3'd5, 32'h0);
    bus_write(3'd1, 32'd4);
    bus_write(3'd2, 32'd64);
    bus_write(3'd3, 32'd256);
    bus_read(3'd3, r);
    bus_write(3'd0, 32'h1);
    collect(7, 100);
    checks++;
    if (got != 7 || sv[4] !== 32'd256 || sv[6] !== 32'd128) begin
      errors++;
      $display("FAIL rst_mid_pre got n=%0d peak=%0d last=%0d want 7/256/128",
               got, sv[4], sv[6]);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (duty_out !== '0 || duty_be !== '0 || readdata !== '0 ||
        period_out !== '0) begin
      errors++;
      $display("FAIL rst_mid_out duty=%h be=%h rd=%h per=%h want 0",
               duty_out, duty_be, readdata, period_out);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    bad = 1'b0;
    repeat (4) begin
      step1();
      if (duty_be !== '0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL rst_mid_strobe got %h want 0", duty_be);
    end
    for (int a = 0; a < 6; a++) begin
      bus_read(3'(a), r);
      checks++;
      if (r !== '0) begin
        errors++;
        $display("FAIL rst_mid_reg%0d got %h want 0", a, r);
      end
    end
  endtask

`ifdef PWM_FADE_IRQ_EN
  task automatic test_irq();
    logic [N-1:0] r;
    bus_write(3'd1, 32'd0);
    bus_write(3'd2, 32'd1);
    bus_write(3'd3, 32'd1);
    bus_write(3'd0, 32'h1);
    step1();
    step1();
    step1();
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_early got %b want 0", irq);
    end
    step1();
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_rise got %b want 1", irq);
    end
    repeat (5) step1();
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_hold got %b want 1", irq);
    end
    bus_write(3'd5, 32'h0);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_clear got %b want 0", irq);
    end
    bus_read(3'd5, r);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("FAIL irq_status got %h want 0", r);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_regs();
    test_fade();
    test_loop();
    test_fast();
    test_step_zero();
    test_max_zero();
    test_period_restart();
    test_reset_mid();
`ifdef PWM_FADE_IRQ_EN
    test_irq();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
